// File: rtl/alu_pkg.sv
// Shared definitions for the extended ALU path: divider state encoding,
// operand width and the divide-by-zero quotient.
package alu_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIN  = 2'd2
  } div_state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_Z_QUOT = '1;

endpackage

// File: rtl/cla_addsub.sv
// Adder/subtractor built from generate/propagate terms. In subtract mode
// b is inverted and the carry-in is 1, so cout=1 means "no borrow".
module cla_addsub #(
  parameter int N = 17
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] bx;
  logic [N-1:0] g;
  logic [N-1:0] p;

  assign bx = b ^ {N{sub}};
  assign g  = a & bx;
  assign p  = a ^ bx;

  // Carry chain from generate/propagate; sum bit uses the carry into that bit.
  always_comb begin
    logic carry;
    sum   = '0;
    carry = sub;
    for (int i = 0; i < N; i++) begin
      sum[i] = p[i] ^ carry;
      carry  = g[i] | (p[i] & carry);
    end
    cout = carry;
  end

endmodule

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, q} left, trial-subtract the
// divisor magnitude, keep the difference and set the quotient bit when it
// did not borrow.
module div_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] q,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] q_next
);

  logic [W:0] shifted;
  logic [W:0] trial;
  logic       no_borrow;
  logic       unused_trial_msb;

  assign shifted = {rem, q[W-1]};

  cla_addsub #(.N(W + 1)) u_sub (
    .a    (shifted),
    .b    ({1'b0, dvs}),
    .sub  (1'b1),
    .sum  (trial),
    .cout (no_borrow)
  );

  // Remainder always stays below the divisor, so the top trial bit is zero
  // whenever it is kept.
  assign unused_trial_msb = trial[W];
  assign rem_next = no_borrow ? trial[W-1:0] : shifted[W-1:0];
  assign q_next   = {q[W-2:0], no_borrow};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, with signed
// (truncating) and unsigned modes, divide-by-zero and overflow flags.
//
// state    | meaning
// DIV_IDLE | waiting for start; results hold
// DIV_CALC | one restoring iteration per clock, WIDTH iterations
// DIV_FIN  | sign fix-up, results and flags registered, done pulsed
module seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             ovfl
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_r, q_r, dvs_abs, dvd_l, dvs_l;
  logic             sgn_l;

  logic [WIDTH-1:0] rem_nx, q_nx;
  logic [WIDTH-1:0] dvd_abs_in, dvs_abs_in;
  logic [WIDTH-1:0] q_fix, rem_fix;
  logic             neg_q, neg_r;

  div_step #(.W(WIDTH)) u_step (
    .rem      (rem_r),
    .q        (q_r),
    .dvs      (dvs_abs),
    .rem_next (rem_nx),
    .q_next   (q_nx)
  );

  // Magnitudes are taken only for signed operands with the sign bit set;
  // -2^(WIDTH-1) maps onto itself, which is its correct unsigned magnitude.
  assign dvd_abs_in = (is_signed && dividend[WIDTH-1]) ? (~dividend + ONE) : dividend;
  assign dvs_abs_in = (is_signed && divisor[WIDTH-1])  ? (~divisor + ONE)  : divisor;

  assign neg_q   = sgn_l & (dvd_l[WIDTH-1] ^ dvs_l[WIDTH-1]);
  assign neg_r   = sgn_l & dvd_l[WIDTH-1];
  assign q_fix   = neg_q ? (~q_r + ONE) : q_r;
  assign rem_fix = (neg_r && rem_r != '0) ? (~rem_r + ONE) : rem_r;

  // Control FSM, iteration datapath and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= DIV_IDLE;
      cnt       <= '0;
      rem_r     <= '0;
      q_r       <= '0;
      dvs_abs   <= '0;
      dvd_l     <= '0;
      dvs_l     <= '0;
      sgn_l     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      ovfl      <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy     <= 1'b1;
            div_zero <= 1'b0;
            ovfl     <= 1'b0;
            sgn_l    <= is_signed;
            dvd_l    <= dividend;
            dvs_l    <= divisor;
            rem_r    <= '0;
            q_r      <= dvd_abs_in;
            dvs_abs  <= dvs_abs_in;
            cnt      <= CNT_W'(WIDTH - 1);
            state    <= (divisor == '0) ? DIV_FIN : DIV_CALC;
          end
        end
        DIV_CALC: begin
          rem_r <= rem_nx;
          q_r   <= q_nx;
          if (cnt == '0) state <= DIV_FIN;
          else           cnt   <= cnt - 1'b1;
        end
        DIV_FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DIV_IDLE;
          if (dvs_l == '0) begin
            quotient  <= DIV_Z_QUOT;
            remainder <= dvd_l;
            div_zero  <= 1'b1;
          end else begin
            quotient  <= q_fix;
            remainder <= rem_fix;
            ovfl      <= sgn_l && (dvd_l == MIN_NEG) && (dvs_l == '1);
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: hand-computed quotients, remainders,
// flags and done latencies.
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_zero;
  logic        ovfl;

  int checks = 0;
  int errors = 0;

  seq_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .ovfl      (ovfl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands and start just after an edge; the next edge accepts.
  task automatic start_op(input logic s, input logic [15:0] a, input logic [15:0] b);
    is_signed = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  // Count edges after the accepting edge until done is seen; optionally
  // pulse start with new operands at edge inject_at.
  task automatic wait_done(input int inject_at, output int lat, output bit busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (n == inject_at) begin
        start = 1'b1; dividend = 16'd50; divisor = 16'd3; is_signed = 1'b0;
      end else if (n == inject_at + 1) begin
        start = 1'b0;
      end
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] q, input logic [15:0] r,
                              input logic dz, input logic ov);
    check_val({tag, " quotient"}, {16'h0, quotient}, {16'h0, q});
    check_val({tag, " remainder"}, {16'h0, remainder}, {16'h0, r});
    check_val({tag, " div_zero"}, {31'h0, div_zero}, {31'h0, dz});
    check_val({tag, " ovfl"}, {31'h0, ovfl}, {31'h0, ov});
  endtask

  initial begin
    int  lat;
    bit  bok;
    bit  seen_done;

    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset busy", {31'h0, busy}, 32'h0);
    check_val("reset done", {31'h0, done}, 32'h0);
    check_result("reset", 16'h0000, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // signed 100 / 7
    start_op(1'b1, 16'd100, 16'd7);
    check_val("accept busy", {31'h0, busy}, 32'h1);
    wait_done(-10, lat, bok);
    check_val("100/7 latency", lat, 32'd17);
    check_val("100/7 busy held", {31'h0, bok}, 32'h1);
    check_val("100/7 busy at done", {31'h0, busy}, 32'h0);
    check_result("100/7", 16'd14, 16'd2, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_val("done one cycle", {31'h0, done}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check_val("idle hold quotient", {16'h0, quotient}, 32'd14);

    // back-to-back with start held: -100/7 then 7/-2
    is_signed = 1'b1; dividend = 16'hFF9C; divisor = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    wait_done(-10, lat, bok);
    check_val("-100/7 latency", lat, 32'd17);
    check_result("-100/7", 16'hFFF2, 16'hFFFE, 1'b0, 1'b0);
    dividend = 16'd7; divisor = 16'hFFFE;
    wait_done(-10, lat, bok);
    start = 1'b0;
    check_val("b2b done spacing", lat, 32'd18);
    check_result("7/-2", 16'hFFFD, 16'd1, 1'b0, 1'b0);
    @(posedge clk); #1;

    // 0xFFFF / 0x10 unsigned and signed
    start_op(1'b0, 16'hFFFF, 16'h0010);
    wait_done(-10, lat, bok);
    check_result("u FFFF/10", 16'h0FFF, 16'h000F, 1'b0, 1'b0);
    start_op(1'b1, 16'hFFFF, 16'h0010);
    wait_done(-10, lat, bok);
    check_result("s -1/16", 16'h0000, 16'hFFFF, 1'b0, 1'b0);

    // divide by zero, then a valid division clears the flag
    start_op(1'b0, 16'd1234, 16'd0);
    wait_done(-10, lat, bok);
    check_val("div0 latency", lat, 32'd1);
    check_result("1234/0", 16'hFFFF, 16'd1234, 1'b1, 1'b0);
    start_op(1'b0, 16'd10, 16'd3);
    check_val("div0 cleared on accept", {31'h0, div_zero}, 32'h0);
    wait_done(-10, lat, bok);
    check_result("10/3", 16'd3, 16'd1, 1'b0, 1'b0);

    // signed overflow and the same operands unsigned
    start_op(1'b1, 16'h8000, 16'hFFFF);
    wait_done(-10, lat, bok);
    check_result("s -32768/-1", 16'h8000, 16'h0000, 1'b0, 1'b1);
    start_op(1'b0, 16'h8000, 16'hFFFF);
    wait_done(-10, lat, bok);
    check_result("u 32768/65535", 16'h0000, 16'h8000, 1'b0, 1'b0);

    // start with new operands while busy is ignored
    start_op(1'b1, 16'd100, 16'd7);
    wait_done(5, lat, bok);
    check_val("ignored start latency", lat, 32'd17);
    check_result("ignored start", 16'd14, 16'd2, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_val("no extra op busy", {31'h0, busy}, 32'h0);

    // reset mid-operation aborts
    start_op(1'b1, 16'd100, 16'd7);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("abort busy", {31'h0, busy}, 32'h0);
    check_val("abort done", {31'h0, done}, 32'h0);
    check_result("abort", 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1'b1;
    end
    check_val("no done after abort", {31'h0, seen_done}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
